// File: rtl/mac_seq.sv
// Operand sequencer and result collector for the mac accumulator: streams one
// neuron's input/weight pairs into mac, then writes the activated result.
module mac_seq #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 32,
  parameter int SHIFT = 0,
  parameter int IA_W  = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int WA_W  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  parameter int OA_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [IA_W-1:0]    in_addr,
  input  logic signed [7:0]  in_rdata,
  output logic [WA_W-1:0]    w_addr,
  input  logic signed [7:0]  w_rdata,
  output logic signed [7:0]  mac_a,
  output logic signed [7:0]  mac_b,
  output logic               mac_clr_n,
  input  logic signed [25:0] mac_acc,
  output logic [OA_W-1:0]    out_addr,
  output logic [7:0]         out_data,
  output logic               out_we,
  output logic               busy,
  output logic               done
);

  // state   | meaning
  // IDLE    | waiting for start
  // CLR     | synchronous clear of mac accumulator
  // MAC     | issue one input/weight address pair per cycle
  // DRAIN   | last pair reaches mac operands
  // WRITE   | acc final; write activated result for current neuron
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_MAC, S_DRAIN, S_WRITE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IA_W-1:0]   r_in_addr;
  logic [WA_W-1:0]   r_w_addr;
  logic [OA_W-1:0]   r_neuron;
  logic              r_vld;
  logic              r_done;
  logic              w_last_i;
  logic              w_last_n;
  logic              w_clr_n;
  logic              w_we;
  logic              w_busy;
  logic              w_issue;
  logic signed [25:0] w_shr;
  logic [7:0]        w_act;

  assign w_last_i = (r_in_addr == IA_W'(N_IN - 1));
  assign w_last_n = (r_neuron == OA_W'(N_OUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_CLR;
      S_CLR:   w_next = S_MAC;
      S_MAC:   if (w_last_i) w_next = S_DRAIN;
      S_DRAIN: w_next = S_WRITE;
      S_WRITE: w_next = w_last_n ? S_IDLE : S_CLR;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_clr_n = 1'b1;
    w_we    = 1'b0;
    w_busy  = 1'b1;
    w_issue = 1'b0;
    unique case (r_state)
      S_IDLE:  w_busy  = 1'b0;
      S_CLR:   w_clr_n = 1'b0;
      S_MAC:   w_issue = 1'b1;
      S_DRAIN: ;
      S_WRITE: w_we    = 1'b1;
      default: w_busy  = 1'b0;
    endcase
  end

  // w_addr runs continuously across neurons, giving neuron*N_IN+i without a multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_addr <= '0;
      r_w_addr  <= '0;
      r_neuron  <= '0;
      r_vld     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_vld  <= w_issue;
      r_done <= w_we && w_last_n;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_in_addr <= '0;
            r_w_addr  <= '0;
            r_neuron  <= '0;
          end
        end
        S_MAC: begin
          r_in_addr <= w_last_i ? '0 : r_in_addr + IA_W'(1);
          r_w_addr  <= r_w_addr + WA_W'(1);
        end
        S_WRITE: r_neuron <= w_last_n ? '0 : r_neuron + OA_W'(1);
        default: ;
      endcase
    end
  end

  assign w_shr = mac_acc >>> SHIFT;

  always_comb begin
    w_act = '0;
    if (!mac_acc[25]) w_act = (|w_shr[25:7]) ? 8'd127 : w_shr[7:0];
  end

  // operands are zero on non-pair cycles because mac accumulates every cycle
  assign mac_a     = r_vld ? in_rdata : '0;
  assign mac_b     = r_vld ? w_rdata  : '0;
  assign mac_clr_n = w_clr_n;
  assign in_addr   = r_in_addr;
  assign w_addr    = r_w_addr;
  assign out_addr  = r_neuron;
  assign out_data  = w_we ? w_act : '0;
  assign out_we    = w_we;
  assign busy      = w_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq: four parameterisations, each with its own
// memory models and a behavioural mac accumulator.
module tb_mac_seq;

  localparam int NG = 4;

  function automatic int ni(input int g);
    case (g)
      0: return 3;
      1: return 3;
      2: return 6;
      default: return 1;
    endcase
  endfunction

  function automatic int no(input int g);
    case (g)
      0: return 2;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int sh(input int g);
    return (g == 1) ? 8 : 0;
  endfunction

  function automatic logic signed [7:0] b8(input int v);
    logic [31:0] t;
    t = v;
    return t[7:0];
  endfunction

  typedef struct {
    int g;
    int addr;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_v [NG];
  logic signed [7:0] in_mem [NG][8];
  logic signed [7:0] w_mem [NG][16];

  int ia_a [NG];
  int wa_a [NG];
  int oa_a [NG];
  int od_a [NG];
  int ma_a [NG];
  int mb_a [NG];
  logic clrn_a [NG];
  logic we_a [NG];
  logic bsy_a [NG];
  logic dn_a [NG];

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int wcnt = 0;
  int dcnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NG; g++) begin : gi
    localparam int P_NI  = ni(g);
    localparam int P_NO  = no(g);
    localparam int P_SH  = sh(g);
    localparam int P_IAW = (P_NI > 1) ? $clog2(P_NI) : 1;
    localparam int P_WAW = (P_NI * P_NO > 1) ? $clog2(P_NI * P_NO) : 1;
    localparam int P_OAW = (P_NO > 1) ? $clog2(P_NO) : 1;

    logic [P_IAW-1:0] ia;
    logic [P_WAW-1:0] wa;
    logic [P_OAW-1:0] oa;
    logic signed [7:0] ird, wrd, ma, mb;
    logic signed [25:0] acc;
    logic [7:0] od;
    logic clrn, we, bsy, dn;

    always @(posedge clk) begin
      ird <= in_mem[g][ia];
      wrd <= w_mem[g][wa];
    end

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n)     acc <= '0;
      else if (!clrn) acc <= '0;
      else            acc <= acc + ma * mb;
    end

    mac_seq #(
      .N_IN(P_NI), .N_OUT(P_NO), .SHIFT(P_SH),
      .IA_W(P_IAW), .WA_W(P_WAW), .OA_W(P_OAW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]),
      .in_addr(ia), .in_rdata(ird), .w_addr(wa), .w_rdata(wrd),
      .mac_a(ma), .mac_b(mb), .mac_clr_n(clrn), .mac_acc(acc),
      .out_addr(oa), .out_data(od), .out_we(we), .busy(bsy), .done(dn)
    );

    assign ia_a[g]   = int'(ia);
    assign wa_a[g]   = int'(wa);
    assign oa_a[g]   = int'(oa);
    assign od_a[g]   = int'(od);
    assign ma_a[g]   = int'(ma);
    assign mb_a[g]   = int'(mb);
    assign clrn_a[g] = clrn;
    assign we_a[g]   = we;
    assign bsy_a[g]  = bsy;
    assign dn_a[g]   = dn;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int g, input int addr, input int data);
    exp_t e;
    e.g = g;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  // hand-computed results per instance
  task automatic push_pass(input int g);
    case (g)
      0: begin push(0, 0, 0); push(0, 1, 25); end
      1: begin push(1, 0, 127); push(1, 1, 0); end
      2: push(2, 0, 0);
      default: push(3, 0, 63);
    endcase
  endtask

  task automatic chk_reset(input int g);
    chk("rst_in_addr", ia_a[g], 0);
    chk("rst_w_addr", wa_a[g], 0);
    chk("rst_out_addr", oa_a[g], 0);
    chk("rst_out_data", od_a[g], 0);
    chk("rst_mac_a", ma_a[g], 0);
    chk("rst_mac_b", mb_a[g], 0);
    chk("rst_mac_clr_n", int'(clrn_a[g]), 1);
    chk("rst_out_we", int'(we_a[g]), 0);
    chk("rst_busy", int'(bsy_a[g]), 0);
    chk("rst_done", int'(dn_a[g]), 0);
  endtask

  task automatic start_pass(input int g);
    push_pass(g);
    start_v[g] = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start_v[g] = 1'b0;
    chk("busy_on_start", int'(bsy_a[g]), 1);
  endtask

  task automatic wait_done(input int g, input int exp_cyc, input string nm);
    int lim;
    lim = cyc + 400;
    while (!dn_a[g] && cyc < lim) @(negedge clk);
    chk(nm, cyc - t0, exp_cyc);
    chk("busy_low_at_done", int'(bsy_a[g]), 0);
  endtask

  // monitor: pops the scoreboard on every write, checks operand gating
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < NG; g++) begin
        if (dn_a[g]) dcnt++;
        if (we_a[g]) begin
          wcnt++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: inst %0d addr %0d data %0d, expected no write", g, oa_a[g], od_a[g]);
          end else begin
            e = sb.pop_front();
            chk("write_inst", g, e.g);
            chk("write_addr", oa_a[g], e.addr);
            chk("write_data", od_a[g], e.data);
          end
        end
        if (!clrn_a[g] || we_a[g] || !bsy_a[g]) begin
          chk("mac_a_zero", ma_a[g], 0);
          chk("mac_b_zero", mb_a[g], 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wsnap, dsnap;
    rst_n = 1'b0;
    for (int g = 0; g < NG; g++) begin
      start_v[g] = 1'b0;
      for (int i = 0; i < 8; i++) in_mem[g][i] = '0;
      for (int i = 0; i < 16; i++) w_mem[g][i] = '0;
    end
    in_mem[0][0] = b8(2);  in_mem[0][1] = b8(-2); in_mem[0][2] = b8(-3);
    w_mem[0][0] = b8(5);   w_mem[0][1] = b8(5);   w_mem[0][2] = b8(8);
    w_mem[0][3] = b8(10);  w_mem[0][4] = b8(-1);  w_mem[0][5] = b8(-1);
    for (int i = 0; i < 3; i++) begin
      in_mem[1][i]  = b8(126);
      w_mem[1][i]   = b8(126);
      w_mem[1][i+3] = b8(-100);
    end
    for (int i = 0; i < 6; i++) begin
      in_mem[2][i] = b8(126);
      w_mem[2][i]  = b8(-100);
    end
    in_mem[3][0] = b8(7);
    w_mem[3][0]  = b8(9);

    repeat (3) @(negedge clk);
    for (int g = 0; g < NG; g++) chk_reset(g);
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NG; g++) chk_reset(g);

    // basic pass: -24 -> 0, 25 -> 25
    wsnap = wcnt;
    start_pass(0);
    wait_done(0, 12, "done_latency_basic");
    chk("we_count_basic", wcnt - wsnap, 2);

    // saturation with SHIFT=8, then negative
    start_pass(1);
    wait_done(1, 12, "done_latency_sat");

    // large negative, N_IN=6
    start_pass(2);
    wait_done(2, 9, "done_latency_neg");

    // N_IN=1, N_OUT=1
    start_pass(3);
    wait_done(3, 4, "done_latency_min");

    // start pulse while busy is ignored
    wsnap = wcnt;
    start_pass(0);
    repeat (3) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 12, "done_latency_busy_start");
    chk("we_count_busy_start", wcnt - wsnap, 2);
    repeat (4) @(negedge clk);
    chk("idle_after_busy_start", int'(bsy_a[0]), 0);

    // start held high: second pass from the done cycle, no third
    wsnap = wcnt;
    dsnap = dcnt;
    push_pass(0);
    push_pass(0);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    wait_done(0, 12, "done_latency_held1");
    @(posedge clk);
    #1;
    t0 = cyc;
    start_v[0] = 1'b0;
    chk("busy_back_to_back", int'(bsy_a[0]), 1);
    wait_done(0, 12, "done_latency_held2");
    repeat (5) @(negedge clk);
    chk("held_no_third_pass", int'(bsy_a[0]), 0);
    chk("we_count_held", wcnt - wsnap, 4);
    chk("done_count_held", dcnt - dsnap, 2);

    // reset during neuron 1 MAC
    start_pass(0);
    while (cyc < t0 + 8) @(negedge clk);
    chk("mid_in_addr", ia_a[0], 1);
    chk("mid_w_addr", wa_a[0], 4);
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    sb.delete();
    wsnap = wcnt;
    dsnap = dcnt;
    repeat (20) @(negedge clk);
    chk("no_write_in_reset", wcnt - wsnap, 0);
    chk("no_done_in_reset", dcnt - dsnap, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset(0);
    start_pass(0);
    wait_done(0, 12, "done_latency_after_reset");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
